// File: rtl/sync_fifo_pkg.sv
// Shared defaults and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_W   = 8;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_AF_LEVEL = 12;
  localparam int unsigned DEF_AE_LEVEL = 2;

  // Pointer width for a given depth; a depth of 1 would give 0 bits, so clamp to 1.
  function automatic int unsigned ptr_w(input int unsigned depth);
    int unsigned w;
    w = $clog2(depth);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : sync_fifo_pkg

// File: rtl/fifo_wrap_ptr.sv
// Wrapping address pointer: counts 0..DEPTH-1 and returns to 0, for any DEPTH.
module fifo_wrap_ptr
  import sync_fifo_pkg::*;
#(
  parameter  int unsigned DEPTH = DEF_DEPTH,
  localparam int unsigned PW    = ptr_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] r_ptr;

  // Advance on inc; explicit compare-and-wrap so non-power-of-two depths work.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule : fifo_wrap_ptr

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with occupancy count, almost flags, flush and sticky error flags.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEF_AF_LEVEL,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL,
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              underflow
);

  localparam int unsigned PW = ptr_w(DEPTH);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic [PW-1:0]     w_wr_ptr;
  logic [PW-1:0]     w_rd_ptr;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;

  // Flags decode straight from the registered count.
  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);

  // Reset and flush both veto any access in the same cycle.
  assign w_wr_acc = rst & ~clr & wr_en & ~w_full;
  assign w_rd_acc = rst & ~clr & rd_en & ~w_empty;

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_wr_acc),
    .ptr (w_wr_ptr)
  );

  fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (w_rd_acc),
    .ptr (w_rd_ptr)
  );

  // Storage write; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[w_wr_ptr] <= wr_data;
    end
  end

  // Occupancy: simultaneous accepted read and write cancel out.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered read port; flush keeps the last word but drops the valid strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (clr) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
      if (w_rd_acc) begin
        r_rd_data <= r_mem[w_rd_ptr];
      end
    end
  end

  // Sticky error flags, cleared only by reset or flush.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_en & w_full);
      r_underflow <= r_underflow | (rd_en & w_empty);
    end
  end

  assign rd_data      = r_rd_data;
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

  a_count_bound : assert property (@(posedge clk) disable iff (!rst) r_count <= FULL_CNT);
  a_full_empty  : assert property (@(posedge clk) disable iff (!rst) !(w_full && w_empty));
  a_valid_src   : assert property (@(posedge clk) disable iff (!rst) r_rd_valid |-> $past(w_rd_acc));

endmodule : sync_fifo_param
